tc_mem_backend: RTL and testbench

TC_MEM_BACKEND -- requirements
Module: tc_mem_backend

---
 rtl/tc_mem_pkg.sv | 18 +
 rtl/tc_mem_array.sv | 22 ++
 rtl/tc_mem_backend.sv | 144 ++++++++++++++
 tb/tb_tc_mem_backend.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tc_mem_pkg.sv
// Shared constants and FSM state type for the line-based test memory backend.
package tc_mem_pkg;

   localparam int DEF_ADDR_WIDTH = 26;
   localparam int DEF_TAG_WIDTH  = 5;
   localparam int DEF_DATA_WIDTH = 128;
   localparam int DEF_BEATS      = 4;
   localparam int DEF_MEM_AW     = 10;
   localparam int DEF_READ_DELAY = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WDATA = 2'd1,
      ST_RWAIT = 2'd2,
      ST_RRESP = 2'd3
   } tc_mem_state_e;

endpackage

// File: rtl/tc_mem_array.sv
// Beat-addressed storage: one write port, one registered read port, no reset.
module tc_mem_array #(
   parameter int DATA_WIDTH = 128,
   parameter int AW         = 12
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/tc_mem_backend.sv
// Single-outstanding line memory backend with burst writes and burst read responses.
// Optional extra read latency is enabled by defining TC_MEM_DELAY_EN.
//
// state    | meaning
// ST_IDLE  | accepting a command
// ST_WDATA | taking BEATS write beats into the latched line
// ST_RWAIT | array read of beat 0 in flight (plus READ_DELAY when enabled)
// ST_RRESP | streaming BEATS read beats
module tc_mem_backend
   import tc_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BEATS      = DEF_BEATS,
   parameter int MEM_AW     = DEF_MEM_AW,
   parameter int READ_DELAY = DEF_READ_DELAY
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  io_mem_req_cmd_ready,
   input  logic                  io_mem_req_cmd_valid,
   input  logic [ADDR_WIDTH-1:0] io_mem_req_cmd_bits_addr,
   input  logic [TAG_WIDTH-1:0]  io_mem_req_cmd_bits_tag,
   input  logic                  io_mem_req_cmd_bits_rw,
   output logic                  io_mem_req_data_ready,
   input  logic                  io_mem_req_data_valid,
   input  logic [DATA_WIDTH-1:0] io_mem_req_data_bits_data,
   output logic                  io_mem_resp_valid,
   output logic [DATA_WIDTH-1:0] io_mem_resp_bits_data,
   output logic [TAG_WIDTH-1:0]  io_mem_resp_bits_tag
);

   localparam int BW = $clog2(BEATS);
   localparam int AW = MEM_AW + BW;

   tc_mem_state_e         state_q, state_d;
   logic [MEM_AW-1:0]     idx_q, idx_d;
   logic [TAG_WIDTH-1:0]  tag_q, tag_d, resp_tag_q;
   logic [BW-1:0]         beat_q, beat_d, rd_beat;
   logic [DATA_WIDTH-1:0] resp_data_q, rd_data;
   logic [AW-1:0]         rd_addr;
   logic                  cmd_fire, data_fire, last_beat, wait_done, rd_en;

   // Upper address bits are deliberately dropped so addresses alias onto MEM_AW lines.
   logic unused_addr;
   assign unused_addr = ^io_mem_req_cmd_bits_addr[ADDR_WIDTH-1:MEM_AW];

   assign io_mem_req_cmd_ready  = (state_q == ST_IDLE) & ~reset;
   assign io_mem_req_data_ready = (state_q == ST_WDATA) & ~reset;
   assign io_mem_resp_valid     = (state_q == ST_RRESP);
   assign io_mem_resp_bits_data = io_mem_resp_valid ? rd_data : resp_data_q;
   assign io_mem_resp_bits_tag  = io_mem_resp_valid ? tag_q : resp_tag_q;

   assign cmd_fire  = io_mem_req_cmd_ready & io_mem_req_cmd_valid;
   assign data_fire = io_mem_req_data_ready & io_mem_req_data_valid;
   assign last_beat = (beat_q == BW'(BEATS - 1));

`ifdef TC_MEM_DELAY_EN
   localparam int DW = (READ_DELAY > 0) ? $clog2(READ_DELAY + 1) : 1;
   logic [DW-1:0] dly_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                     dly_q <= '0;
      else if (cmd_fire)                             dly_q <= DW'(READ_DELAY);
      else if (state_q == ST_RWAIT && dly_q != '0)   dly_q <= dly_q - 1'b1;
   end
   assign wait_done = (dly_q == '0);
`else
   logic unused_delay;
   assign unused_delay = (READ_DELAY > 0);
   assign wait_done    = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tag_d   = tag_q;
      beat_d  = beat_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               idx_d   = io_mem_req_cmd_bits_addr[MEM_AW-1:0];
               tag_d   = io_mem_req_cmd_bits_tag;
               beat_d  = '0;
               state_d = io_mem_req_cmd_bits_rw ? ST_WDATA : ST_RWAIT;
            end
         end
         ST_WDATA: begin
            if (data_fire) begin
               beat_d = beat_q + 1'b1;
               if (last_beat) state_d = ST_IDLE;
            end
         end
         ST_RWAIT: begin
            if (wait_done) state_d = ST_RRESP;
         end
         ST_RRESP: begin
            beat_d = beat_q + 1'b1;
            if (last_beat) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         tag_q       <= '0;
         beat_q      <= '0;
         resp_data_q <= '0;
         resp_tag_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tag_q   <= tag_d;
         beat_q  <= beat_d;
         if (io_mem_resp_valid) begin
            resp_data_q <= rd_data;
            resp_tag_q  <= tag_q;
         end
      end
   end

   // Read one beat ahead so each RRESP cycle sees its beat straight off the array register.
   assign rd_beat = (state_q == ST_RRESP) ? beat_q + 1'b1 : '0;
   assign rd_addr = {idx_q, rd_beat};
   assign rd_en   = (state_q == ST_RWAIT) | (state_q == ST_RRESP);

   tc_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (AW)
   ) u_array (
      .clk     (clk),
      .we_i    (data_fire),
      .waddr_i ({idx_q, beat_q}),
      .wdata_i (io_mem_req_data_bits_data),
      .re_i    (rd_en),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

endmodule

// File: tb/tb_tc_mem_backend.sv
// Directed self-checking bench for tc_mem_backend; latency follows TC_MEM_DELAY_EN.
module tb_tc_mem_backend;

`ifdef TC_MEM_DELAY_EN
   localparam int LAT = 2 + 8;
`else
   localparam int LAT = 2;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_ready;
   logic          cmd_valid = 1'b0;
   logic [25:0]   cmd_addr = '0;
   logic [4:0]    cmd_tag = '0;
   logic          cmd_rw = 1'b0;
   logic          data_ready;
   logic          data_valid = 1'b0;
   logic [127:0]  data_in = '0;
   logic          resp_valid;
   logic [127:0]  resp_data;
   logic [4:0]    resp_tag;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   tc_mem_backend dut (
      .clk                       (clk),
      .reset                     (reset),
      .io_mem_req_cmd_ready      (cmd_ready),
      .io_mem_req_cmd_valid      (cmd_valid),
      .io_mem_req_cmd_bits_addr  (cmd_addr),
      .io_mem_req_cmd_bits_tag   (cmd_tag),
      .io_mem_req_cmd_bits_rw    (cmd_rw),
      .io_mem_req_data_ready     (data_ready),
      .io_mem_req_data_valid     (data_valid),
      .io_mem_req_data_bits_data (data_in),
      .io_mem_resp_valid         (resp_valid),
      .io_mem_resp_bits_data     (resp_data),
      .io_mem_resp_bits_tag      (resp_tag)
   );

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Starts and ends #1 after a rising edge.
   task automatic do_write(input logic [25:0] a, input logic [4:0] t, input logic [127:0] base, input int nbeats);
      cmd_valid = 1'b1; cmd_addr = a; cmd_tag = t; cmd_rw = 1'b1;
      @(negedge clk);
      chk("wr_cmd_ready", 128'(cmd_ready), 128'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         data_valid = 1'b1;
         data_in    = base + 128'(i);
         @(negedge clk);
         chk("wr_data_ready", 128'(data_ready), 128'd1);
         @(posedge clk); #1;
      end
      data_valid = 1'b0;
   endtask

   // Called in the cycle after the read handshake.
   task automatic chk_resp(input logic [4:0] t, input logic [127:0] base);
      int lat;
      lat = 1;
      @(negedge clk);
      while (!resp_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      chk("rd_latency", 128'(lat), 128'(LAT));
      for (int i = 0; i < 4; i++) begin
         chk("rd_valid", 128'(resp_valid), 128'd1);
         chk("rd_data", resp_data, base + 128'(i));
         chk("rd_tag", 128'(resp_tag), 128'(t));
         @(negedge clk);
      end
      chk("rd_valid_end", 128'(resp_valid), 128'd0);
      chk("rd_data_hold", resp_data, base + 128'd3);
      chk("rd_tag_hold", 128'(resp_tag), 128'(t));
      chk("rd_cmd_ready_end", 128'(cmd_ready), 128'd1);
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [25:0] a, input logic [4:0] t, input logic [127:0] base);
      cmd_valid = 1'b1; cmd_addr = a; cmd_tag = t; cmd_rw = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk_resp(t, base);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int beats;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", 128'(cmd_ready), 128'd0);
      chk("rst_data_ready", 128'(data_ready), 128'd0);
      chk("rst_resp_valid", 128'(resp_valid), 128'd0);
      chk("rst_resp_data", resp_data, 128'd0);
      chk("rst_resp_tag", 128'(resp_tag), 128'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_cmd_ready", 128'(cmd_ready), 128'd1);
      @(posedge clk); #1;

      // Basic write/read, read right after the write completes
      do_write(26'h5, 5'd3, 128'hA0, 4);
      do_read(26'h5, 5'd7, 128'hA0);

      // Write beats while idle and during a read must be ignored
      data_valid = 1'b1; data_in = 128'hDEAD;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_data_ready", 128'(data_ready), 128'd0);
         @(posedge clk); #1;
      end
      do_read(26'h5, 5'd9, 128'hA0);
      data_valid = 1'b0;

      // Command held during a read is only accepted after the last beat
      cmd_valid = 1'b1; cmd_addr = 26'h5; cmd_tag = 5'd1; cmd_rw = 1'b0;
      @(posedge clk); #1;
      cmd_tag = 5'd2;
      n = 1; beats = 0;
      @(negedge clk);
      while (!cmd_ready && n < 60) begin
         beats += int'(resp_valid);
         @(negedge clk);
         n++;
      end
      chk("busy_cmd_ready_rise", 128'(n), 128'(LAT + 4));
      chk("busy_beats", 128'(beats), 128'd4);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk_resp(5'd2, 128'hA0);

      // Aliasing of upper address bits
      do_write(26'h400, 5'd4, 128'hB0, 4);
      do_read(26'h0, 5'd5, 128'hB0);
      do_read(26'h5, 5'd6, 128'hA0);

      // Reset after two beats of a write
      do_write(26'h9, 5'd8, 128'hC0, 4);
      do_write(26'h9, 5'd8, 128'hD0, 2);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_cmd_ready", 128'(cmd_ready), 128'd0);
      chk("mid_rst_data_ready", 128'(data_ready), 128'd0);
      chk("mid_rst_resp_valid", 128'(resp_valid), 128'd0);
      chk("mid_rst_resp_data", resp_data, 128'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_release", 128'(cmd_ready), 128'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_addr = 26'h9; cmd_tag = 5'd10; cmd_rw = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n = 1;
      @(negedge clk);
      while (!resp_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("partial_latency", 128'(n), 128'(LAT));
      chk("partial_b0", resp_data, 128'hD0);
      @(negedge clk);
      chk("partial_b1", resp_data, 128'hD1);
      @(negedge clk);
      chk("partial_b2", resp_data, 128'hC2);
      @(negedge clk);
      chk("partial_b3", resp_data, 128'hC3);
      chk("partial_tag", 128'(resp_tag), 128'd10);
      repeat (2) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
